// File: rtl/div_seq_if.sv
// div_seq request/result bundle.
// master drives operands, slave returns results.
interface div_seq_if;
  logic       ena;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       valid;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       dz;

  modport master (
    output ena, start, dividend, divisor,
    input  busy, valid, quotient, remainder, dz
  );

  modport slave (
    input  ena, start, dividend, divisor,
    output busy, valid, quotient, remainder, dz
  );
endinterface

// File: rtl/div_seq.sv
// div_seq: 8/4-bit unsigned restoring divider, one bit per clk.
// DIVZ_FLAG_EN: divisor 0 short-circuits to q=0, r=0, dz=1.
module div_seq (
  input  logic     clk,
  input  logic     rst,
  div_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t     state;
  logic [7:0] dvd;
  logic [3:0] dvs;
  logic [4:0] pr;
  logic [2:0] cnt;
  logic       busy_q;
  logic       valid_q;
  logic       dz_q;
  logic [7:0] quo_q;
  logic [3:0] rem_q;

  logic [4:0] shf;
  logic [4:0] dif;
  logic [4:0] pr_nx;
  logic       ge;
  logic       zdiv;

  // one restoring step: shift in next dividend bit, trial subtract
  always_comb begin
    shf   = {pr[3:0], dvd[7]};
    dif   = shf - {1'b0, dvs};
    ge    = (shf >= {1'b0, dvs});
    pr_nx = ge ? dif : shf;
  end

`ifdef DIVZ_FLAG_EN
  assign zdiv = (dvs == 4'd0);
`else
  assign zdiv = 1'b0;
`endif

  // control FSM, datapath and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      dvd     <= '0;
      dvs     <= '0;
      pr      <= '0;
      cnt     <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      dz_q    <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else if (!bus.ena) begin
      state   <= IDLE;
      dvd     <= '0;
      dvs     <= '0;
      pr      <= '0;
      cnt     <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      dz_q    <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else begin
      valid_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= RUN;
            busy_q <= 1'b1;
            dvd    <= bus.dividend;
            dvs    <= bus.divisor;
            pr     <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          if (zdiv) begin
            state   <= DONE;
            quo_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b1;
            valid_q <= 1'b1;
          end else begin
            pr  <= pr_nx;
            dvd <= {dvd[6:0], ge};
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              state   <= DONE;
              quo_q   <= {dvd[6:0], ge};
              rem_q   <= pr_nx[3:0];
              dz_q    <= 1'b0;
              valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.valid     = valid_q;
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
  assign bus.dz        = dz_q;

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: random + directed bench for div_seq.
// Cycle-level scoreboard built from plain / and % arithmetic.
module tb_div_seq;

  logic clk;
  logic rst;
  int   cyc;
  int   n_chk;
  int   n_err;

  div_seq_if bus ();

  div_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference state: an op is a scheduled event, not an FSM
  bit         m_busy;
  bit         m_valid;
  logic [7:0] m_q;
  logic [3:0] m_r;
  bit         m_dz;
  int         m_done;
  logic [7:0] p_q;
  logic [3:0] p_r;
  bit         p_dz;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc %0d got %0h exp %0h",
               tag, cyc, got, exp);
    end
  endtask

  task automatic ref_div(input  logic [7:0] a,
                         input  logic [3:0] b,
                         output logic [7:0] q,
                         output logic [3:0] r,
                         output bit         z,
                         output int         lat);
    if (b == 4'd0) begin
`ifdef DIVZ_FLAG_EN
      q = 8'd0; r = 4'd0; z = 1'b1; lat = 1;
`else
      q = 8'hFF; r = a[3:0]; z = 1'b0; lat = 8;
`endif
    end else begin
      q   = a / {4'd0, b};
      r   = 4'(a % {4'd0, b});
      z   = 1'b0;
      lat = 8;
    end
  endtask

  task automatic m_zero();
    m_busy  = 1'b0;
    m_valid = 1'b0;
    m_q     = '0;
    m_r     = '0;
    m_dz    = 1'b0;
  endtask

  task automatic model_edge();
    int lat;
    if (!rst || !bus.ena) begin
      m_zero();
    end else begin
      m_valid = 1'b0;
      if (m_busy) begin
        if (cyc == m_done) begin
          m_q     = p_q;
          m_r     = p_r;
          m_dz    = p_dz;
          m_valid = 1'b1;
        end else if (cyc == m_done + 1) begin
          m_busy = 1'b0;
        end
      end else if (bus.start) begin
        ref_div(bus.dividend, bus.divisor, p_q, p_r, p_dz, lat);
        m_busy = 1'b1;
        m_done = cyc + lat;
      end
    end
  endtask

  task automatic compare();
    chk("busy",  32'(bus.busy),      32'(m_busy));
    chk("valid", 32'(bus.valid),     32'(m_valid));
    chk("quot",  32'(bus.quotient),  32'(m_q));
    chk("rem",   32'(bus.remainder), 32'(m_r));
    chk("dz",    32'(bus.dz),        32'(m_dz));
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic drive(input bit s,
                       input logic [7:0] a,
                       input logic [3:0] b);
    bus.start    = s;
    bus.dividend = a;
    bus.divisor  = b;
  endtask

  task automatic scramble(input int n);
    repeat (n) begin
      bus.dividend = 8'($urandom);
      bus.divisor  = 4'($urandom);
      tick();
    end
  endtask

  initial begin
    cyc   = 0;
    n_chk = 0;
    n_err = 0;
    m_zero();
    m_done  = 0;
    rst     = 1'b0;
    bus.ena = 1'b0;
    drive(1'b0, 8'd0, 4'd0);

    #1 compare();
    @(negedge clk);
    bus.ena = 1'b1;
    drive(1'b1, 8'd77, 4'd3);
    ticks(2);

    // first accept on first edge out of reset, 200/7
    rst = 1'b1;
    drive(1'b1, 8'd200, 4'd7);
    tick();
    drive(1'b0, 8'd0, 4'd0);
    ticks(12);

    // 255/15 then 5/9 held: ignored in RUN/DONE, taken at k+10
    drive(1'b1, 8'd255, 4'd15);
    tick();
    drive(1'b1, 8'd5, 4'd9);
    ticks(10);
    drive(1'b0, 8'd0, 4'd0);
    ticks(12);

    // divide by zero
    drive(1'b1, 8'd13, 4'd0);
    tick();
    drive(1'b0, 8'd0, 4'd0);
    ticks(12);

    // 100/1 with start held 12 cycles
    drive(1'b1, 8'd100, 4'd1);
    ticks(12);
    drive(1'b0, 8'd0, 4'd0);
    ticks(12);

    // operands churn during RUN
    drive(1'b1, 8'd200, 4'd7);
    tick();
    bus.start = 1'b0;
    scramble(12);

    // ena drop at k+4 discards the op
    drive(1'b1, 8'd200, 4'd7);
    tick();
    drive(1'b0, 8'd0, 4'd0);
    ticks(3);
    bus.ena = 1'b0;
    tick();
    bus.ena = 1'b1;
    ticks(12);

    // async reset mid-op
    drive(1'b1, 8'd200, 4'd7);
    tick();
    drive(1'b0, 8'd0, 4'd0);
    ticks(3);
    rst = 1'b0;
    #1;
    m_zero();
    compare();
    tick();
    rst = 1'b1;
    ticks(12);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      bus.start    = ($urandom_range(0, 2) == 0);
      bus.dividend = 8'($urandom);
      bus.divisor  = ($urandom_range(0, 7) == 0) ?
                     4'd0 : 4'($urandom);
      bus.ena      = ($urandom_range(0, 63) != 0);
      tick();
    end
    bus.ena = 1'b1;
    drive(1'b0, 8'd0, 4'd0);
    ticks(12);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
